coin_acceptor: RTL and testbench
================================

# coin_acceptor

Front-end coin acceptor that drives the 2-bit COIN bus consumed by the vending FSM. Filters and times the raw pulse from the coin sensor, classifies each pulse as Rs5, Rs10 or invalid, and buffers valid coins in a small queue. Issues each coin as a one-cycle COIN code only while the vending FSM is not dispensing, so no coin is lost during its OPEN cycles.

## Interface
- DEPTH, 4, coin queue entries (power of two, ≥2)
- CNT_W, 8, pulse-width counter width
- GLITCH_MAX, 3, pulses of ≤ this many cycles are ignored silently
- W5_MIN, 8 / W5_MAX, 15, inclusive width window for an Rs5 coin (cycles)
- W10_MIN, 20 / W10_MAX, 31, inclusive width window for an Rs10 coin (cycles)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- coin_sense  in  1  raw asynchronous sensor level, high while a coin passes
- vend_busy  in  1  high while the vending FSM is dispensing (its OPEN output)
- COIN  out  2  registered coin code: 00 none, 01 Rs5, 10 Rs10; 11 never driven
- reject  out  1  one-cycle pulse: coin returned (bad width or queue full)
- queue_full  out  1  registered, high while the queue holds DEPTH coins

## Operation
- Reset: COIN=00, reject=0, queue_full=0, queue emptied, synchronizer flops=0, FSM=IDLE, width counter=0.
- coin_sense passes through a 2-flop synchronizer; s = second flop; edges are detected on s.
- Measurement FSM:
  - IDLE: s=1 → MEASURE, counter=1. Otherwise stay.
  - MEASURE: s=1 → counter+1, saturating at 2^CNT_W−1. s=0 → IDLE, classify the counter value w.
- Classification at the MEASURE→IDLE edge:
  - w ≤ GLITCH_MAX: no action.
  - W5_MIN ≤ w ≤ W5_MAX: enqueue Rs5.
  - W10_MIN ≤ w ≤ W10_MAX: enqueue Rs10.
  - Any other w, including saturated: reject=1 for the next cycle.
- Enqueue while full, with no pop on the same edge: the coin is dropped and reject=1. If a pop occurs on the same edge, the enqueue is accepted.
- Issuer, evaluated at each edge:
  - Pop the head and register its code on COIN for exactly one cycle when all of these hold: the queue is non-empty, vend_busy=0 in the current cycle, COIN is currently 00, and the previous cycle was not an issue cycle.
  - Otherwise COIN=00.
  - Result: every issue is followed by at least one 00 cycle, so vend_busy from the resulting dispense is visible before the next issue.
- Queue order is FIFO. Coins are never reordered or duplicated.

## Timing
- Sensor rise to MEASURE: 2-cycle synchronizer delay, plus 1 edge.
- w equals the number of cycles s was high.
- Enqueue to COIN: with vend_busy=0 and the issuer idle, COIN is valid in the cycle after the enqueue edge (1-cycle latency). Empty-queue bypass is not allowed.
- Maximum issue rate is one coin every 2 cycles.
- reject is registered, 1 cycle wide. An invalid pulse and a full-drop cannot coincide, so there is at most one reject per classification.
- queue_full updates on the same edge as the push or pop.
- An asynchronous reset mid-measurement or mid-issue discards the partial pulse and all queued coins. COIN=00 immediately.
- A sensor pulse still high when reset deasserts is measured from the first sampled high, so it will normally classify short or invalid.

## Structure
- Shared package vend_pkg:
  - coin_t enum: COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10. This type is also used by the vending FSM's COIN input.
  - meas_state_t enum: IDLE, MEASURE.
- Sub-module coin_fifo:
  - Parameterized synchronous FIFO, DEPTH × 1 bit; the bit encodes Rs5/Rs10.
  - Ports: push, pop, din, dout, empty, full.
  - Pointers are log2(DEPTH)+1 bits with a wrap bit.
- Top level contains the synchronizer, measurement FSM, classifier and issuer.

## Test plan
- 10-cycle pulse, vend_busy=0 → single COIN=01 cycle, 1 cycle after enqueue; reject stays 0.
- 25-cycle pulse → single COIN=10. 2-cycle pulse → no COIN, no reject. 17-cycle and 40-cycle pulses → one reject pulse each.
- 300-cycle pulse (saturates at 255) → reject, no COIN.
- vend_busy=1, send five Rs5 pulses → queue_full=1 after the fourth, reject on the fifth. Then release vend_busy → four COIN=01 cycles spaced exactly 2 cycles apart.
- Issue Rs10 with vend_busy driven high on the following cycle for 1 cycle → next queued coin is not issued until vend_busy=0. No COIN code appears while vend_busy=1.
- Assert reset mid-MEASURE with 2 coins queued → COIN=00, queue_full=0, no later COIN or reject. The next valid pulse is handled normally.

Source files
------------

// File: rtl/vend_pkg.sv
// Types shared between the coin acceptor and the vending FSM, plus the
// pulse-width classification rule used by the acceptor.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_t;

  typedef enum logic [1:0] {
    CLS_NONE = 2'b00,
    CLS_5    = 2'b01,
    CLS_10   = 2'b10,
    CLS_BAD  = 2'b11
  } cls_t;

  // Glitches are checked first so a tiny pulse is never reported as bad.
  function automatic cls_t classify_width(
    input int unsigned w,
    input int unsigned glitch_max,
    input int unsigned w5_min,
    input int unsigned w5_max,
    input int unsigned w10_min,
    input int unsigned w10_max
  );
    if (w <= glitch_max) return CLS_NONE;
    if (w >= w5_min && w <= w5_max) return CLS_5;
    if (w >= w10_min && w <= w10_max) return CLS_10;
    return CLS_BAD;
  endfunction

endpackage

// File: rtl/coin_fifo.sv
// DEPTH x 1-bit coin queue (0 = Rs5, 1 = Rs10). A push into a full queue is
// accepted only when a pop frees the head slot on the same edge.
module coin_fifo
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic empty,
  output logic full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && !empty_q;
    do_push = push && (!full_q || do_pop);
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = din;
    // Wrap bit distinguishes full from empty when the index bits match.
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_q[AW-1:0]];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and times the coin sensor pulse,
// classifies it, queues valid coins and issues them to the vending FSM.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GLITCH_MAX = 3,
  parameter int unsigned W5_MIN     = 8,
  parameter int unsigned W5_MAX     = 15,
  parameter int unsigned W10_MIN    = 20,
  parameter int unsigned W10_MAX    = 31
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  coin_sense,
  input  logic  vend_busy,
  output coin_t COIN,
  output logic  reject,
  output logic  queue_full
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  meas_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  coin_t             coin_q, coin_d;
  logic              reject_q, reject_d;

  cls_t              cls;
  logic              push, push_10, pop;
  logic              fifo_dout, fifo_empty, fifo_full;

  // Stage: two-flop synchronizer on the raw sensor level
  always_comb begin
    sync1_d = coin_sense;
    sync2_d = sync1_q;
  end

  // Stage: width measurement and classification on the falling edge of s
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cls     = CLS_NONE;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (sync2_q) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          cls     = classify_width(32'(cnt_q), GLITCH_MAX, W5_MIN, W5_MAX,
                                   W10_MIN, W10_MAX);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage: issuer; a non-zero COIN blocks the next pop, forcing a 00 gap
  always_comb begin
    push     = (cls == CLS_5) || (cls == CLS_10);
    push_10  = (cls == CLS_10);
    pop      = !fifo_empty && !vend_busy && (coin_q == COIN_NONE);
    coin_d   = COIN_NONE;
    if (pop) begin
      if (fifo_dout) coin_d = COIN_10;
      else           coin_d = COIN_5;
    end
    reject_d = (cls == CLS_BAD) || (push && fifo_full && !pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
    end
  end

  coin_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_10),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign COIN       = coin_q;
  assign reject     = reject_q;
  assign queue_full = fifo_full;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus randomized
// pulses compared against a cycle-level behavioural model of the acceptor.
module tb_coin_acceptor;

  localparam int DEPTH   = 4;
  localparam int SAT     = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_sense = 1'b0;
  logic       vend_busy = 1'b0;
  logic [1:0] coin;
  logic       reject;
  logic       queue_full;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // behavioural model state
  bit m_hist0, m_hist1;
  int m_run;
  int m_q[$];
  int m_coin;
  bit m_rej;

  // event logs filled by the monitor
  int dut_ev[$];
  int dut_cyc[$];
  int mdl_ev[$];
  int rej_cyc[$];
  int dut_rej;
  int mdl_rej;
  int cyc_mm;
  int busy_viol;

  coin_acceptor dut (
    .clk        (clk),
    .reset      (reset),
    .coin_sense (coin_sense),
    .vend_busy  (vend_busy),
    .COIN       (coin),
    .reject     (reject),
    .queue_full (queue_full)
  );

  always #5 clk = ~clk;

  // Model: the FSM sees the sensor as sampled two edges earlier; a run of
  // highs ending in a low is classified, the queue and issuer follow the rules.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      m_hist0 = 0; m_hist1 = 0; m_run = 0; m_q.delete(); m_coin = 0; m_rej = 0;
    end else begin
      bit s;
      bit rej;
      bit issue;
      int code;
      int pre;
      s = m_hist1;
      m_hist1 = m_hist0;
      m_hist0 = coin_sense;
      code = 0;
      rej = 0;
      if (s) begin
        m_run = (m_run < SAT) ? m_run + 1 : SAT;
      end else if (m_run > 0) begin
        if (m_run <= 3) code = 0;
        else if (m_run >= 8 && m_run <= 15) code = 1;
        else if (m_run >= 20 && m_run <= 31) code = 2;
        else rej = 1;
        m_run = 0;
      end
      pre = m_q.size();
      issue = (pre > 0) && !vend_busy && (m_coin == 0);
      if (issue) m_coin = m_q.pop_front();
      else m_coin = 0;
      if (code != 0) begin
        if (pre < DEPTH || issue) m_q.push_back(code);
        else rej = 1;
      end
      m_rej = rej;

      if (coin !== 2'(m_coin) || reject !== m_rej || queue_full !== (m_q.size() == DEPTH))
        cyc_mm++;
      if (coin !== 2'b00) begin
        dut_ev.push_back(int'(coin));
        dut_cyc.push_back(cyc);
        if (vend_busy) busy_viol++;
      end
      if (m_coin != 0) mdl_ev.push_back(m_coin);
      if (reject === 1'b1) begin
        dut_rej++;
        rej_cyc.push_back(cyc);
      end
      if (m_rej) mdl_rej++;
    end
  end

  task automatic clear_logs();
    dut_ev.delete(); dut_cyc.delete(); mdl_ev.delete(); rej_cyc.delete();
    dut_rej = 0; mdl_rej = 0; cyc_mm = 0; busy_viol = 0;
  endtask

  // Called at a falling edge: sensor high for len samples, then low for gap.
  task automatic pulse(input int len, input int gap);
    coin_sense = 1'b1;
    repeat (len) @(negedge clk);
    coin_sense = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    coin_sense = 1'b0;
    vend_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (coin !== 2'b00) begin failures++; $display("FAIL reset_coin got=%b want=00", coin); end
    checks++;
    if (reject !== 1'b0) begin failures++; $display("FAIL reset_reject got=%b want=0", reject); end
    checks++;
    if (queue_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", queue_full); end
    reset = 1'b0;
    clear_logs();
    repeat (3) @(negedge clk);
    checks++;
    if (coin !== 2'b00 || reject !== 1'b0 || queue_full !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got coin=%b rej=%b full=%b want 00/0/0", coin, reject, queue_full);
    end
  endtask

  task automatic test_single_coins();
    int lens[6]  = '{10, 25, 2, 17, 40, 300};
    int codes[6] = '{1, 2, 0, 0, 0, 0};
    int rejs[6]  = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      int c0;
      clear_logs();
      c0 = cyc;
      pulse(lens[i], 10);
      checks++;
      if (dut_ev.size() != (codes[i] != 0 ? 1 : 0)) begin
        failures++;
        $display("FAIL single_coin_count len=%0d got=%0d want=%0d", lens[i], dut_ev.size(), codes[i] != 0);
      end else if (codes[i] != 0) begin
        checks++;
        if (dut_ev[0] != codes[i]) begin
          failures++;
          $display("FAIL single_coin_code len=%0d got=%0d want=%0d", lens[i], dut_ev[0], codes[i]);
        end
        checks++;
        if (dut_cyc[0] != c0 + lens[i] + 4) begin
          failures++;
          $display("FAIL single_coin_latency len=%0d got=%0d want=%0d", lens[i], dut_cyc[0], c0 + lens[i] + 4);
        end
      end
      checks++;
      if (dut_rej != rejs[i]) begin
        failures++;
        $display("FAIL single_reject_count len=%0d got=%0d want=%0d", lens[i], dut_rej, rejs[i]);
      end else if (rejs[i] != 0) begin
        checks++;
        if (rej_cyc[0] != c0 + lens[i] + 3) begin
          failures++;
          $display("FAIL single_reject_time len=%0d got=%0d want=%0d", lens[i], rej_cyc[0], c0 + lens[i] + 3);
        end
      end
      checks++;
      if (cyc_mm != 0) begin
        failures++;
        $display("FAIL single_model len=%0d mismatching_cycles=%0d want=0", lens[i], cyc_mm);
      end
    end
  endtask

  task automatic test_queue_full();
    clear_logs();
    vend_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse(10, 6);
      if (i == 2) begin
        checks++;
        if (queue_full !== 1'b0) begin failures++; $display("FAIL full_after3 got=%b want=0", queue_full); end
      end
      if (i == 3) begin
        checks++;
        if (queue_full !== 1'b1) begin failures++; $display("FAIL full_after4 got=%b want=1", queue_full); end
        checks++;
        if (dut_rej != 0) begin failures++; $display("FAIL full_no_reject got=%0d want=0", dut_rej); end
      end
    end
    checks++;
    if (dut_rej != 1) begin failures++; $display("FAIL full_drop_reject got=%0d want=1", dut_rej); end
    checks++;
    if (dut_ev.size() != 0) begin failures++; $display("FAIL full_busy_issue got=%0d want=0", dut_ev.size()); end
    vend_busy = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (dut_ev.size() != 4) begin
      failures++;
      $display("FAIL drain_count got=%0d want=4", dut_ev.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_ev[k] != 1) begin failures++; $display("FAIL drain_code idx=%0d got=%0d want=1", k, dut_ev[k]); end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (dut_cyc[k] - dut_cyc[k-1] != 2) begin
          failures++;
          $display("FAIL drain_spacing idx=%0d got=%0d want=2", k, dut_cyc[k] - dut_cyc[k-1]);
        end
      end
    end
    checks++;
    if (queue_full !== 1'b0) begin failures++; $display("FAIL drain_full got=%b want=0", queue_full); end
    checks++;
    if (cyc_mm != 0) begin failures++; $display("FAIL full_model mismatching_cycles=%0d want=0", cyc_mm); end
  endtask

  task automatic test_busy_gap();
    bit seen;
    vend_busy = 1'b1;
    pulse(25, 8);
    pulse(10, 8);
    clear_logs();
    vend_busy = 1'b0;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (dut_ev.size() > 0) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL busy_first_issue got=none want=coin within 10 cycles");
    end else begin
      vend_busy = 1'b1;
      repeat (2) @(negedge clk);
      vend_busy = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (dut_ev.size() != 2) begin
        failures++;
        $display("FAIL busy_count got=%0d want=2", dut_ev.size());
      end else begin
        checks++;
        if (dut_ev[0] != 2 || dut_ev[1] != 1) begin
          failures++;
          $display("FAIL busy_order got=%0d,%0d want=2,1", dut_ev[0], dut_ev[1]);
        end
        checks++;
        if (dut_cyc[1] - dut_cyc[0] != 3) begin
          failures++;
          $display("FAIL busy_hold_gap got=%0d want=3", dut_cyc[1] - dut_cyc[0]);
        end
      end
    end
    checks++;
    if (busy_viol != 0) begin failures++; $display("FAIL busy_issue_while_busy got=%0d want=0", busy_viol); end
  endtask

  task automatic test_reset_mid();
    int c0;
    vend_busy = 1'b1;
    pulse(10, 8);
    pulse(25, 8);
    coin_sense = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (coin !== 2'b00 || queue_full !== 1'b0 || reject !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs got coin=%b full=%b rej=%b want 00/0/0", coin, queue_full, reject);
    end
    coin_sense = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_logs();
    vend_busy = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (dut_ev.size() != 0 || dut_rej != 0) begin
      failures++;
      $display("FAIL midreset_leftover got coins=%0d rejects=%0d want 0/0", dut_ev.size(), dut_rej);
    end
    clear_logs();
    c0 = cyc;
    pulse(25, 10);
    checks++;
    if (dut_ev.size() != 1 || (dut_ev.size() == 1 && dut_ev[0] != 2)) begin
      failures++;
      $display("FAIL midreset_next_coin got count=%0d want one Rs10", dut_ev.size());
    end else begin
      checks++;
      if (dut_cyc[0] != c0 + 29) begin
        failures++;
        $display("FAIL midreset_latency got=%0d want=%0d", dut_cyc[0], c0 + 29);
      end
    end
  endtask

  task automatic test_random();
    clear_logs();
    for (int i = 0; i < 60; i++) begin
      int len;
      case ($urandom_range(0, 5))
        0: len = $urandom_range(1, 5);
        1: len = $urandom_range(7, 16);
        2: len = $urandom_range(19, 32);
        3: len = $urandom_range(1, 45);
        4: len = $urandom_range(8, 31);
        default: len = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 270) : $urandom_range(4, 35);
      endcase
      vend_busy = ($urandom_range(0, 2) == 0);
      pulse(len, $urandom_range(1, 12));
    end
    vend_busy = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (cyc_mm != 0) begin failures++; $display("FAIL random_model mismatching_cycles=%0d want=0", cyc_mm); end
    checks++;
    if (dut_ev.size() != mdl_ev.size()) begin
      failures++;
      $display("FAIL random_coin_count got=%0d want=%0d", dut_ev.size(), mdl_ev.size());
    end else begin
      for (int k = 0; k < dut_ev.size(); k++) begin
        checks++;
        if (dut_ev[k] != mdl_ev[k]) begin
          failures++;
          $display("FAIL random_coin_seq idx=%0d got=%0d want=%0d", k, dut_ev[k], mdl_ev[k]);
        end
      end
    end
    checks++;
    if (dut_rej != mdl_rej) begin failures++; $display("FAIL random_reject_count got=%0d want=%0d", dut_rej, mdl_rej); end
    checks++;
    if (busy_viol != 0) begin failures++; $display("FAIL random_issue_while_busy got=%0d want=0", busy_viol); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_coins();
    test_queue_full();
    test_busy_gap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
